// File: rtl/alu_pwr_seq_if.sv
// Control/status bundle between an ALU power requester and the sequencer.
// master: the requesting side (drives requests and ALU activity, observes status).
// slave:  the sequencer (alu_pwr_seq).
interface alu_pwr_seq_if;
    logic       pwr_req;
    logic       auto_off_en;
    logic       start_in;
    logic       alu_busy;
    logic       alu_pwr_en;
    logic       iso_en;
    logic       alu_rst_n;
    logic       alu_ready;
    logic [2:0] pwr_state;

    modport master (
        output pwr_req, auto_off_en, start_in, alu_busy,
        input  alu_pwr_en, iso_en, alu_rst_n, alu_ready, pwr_state
    );

    modport slave (
        input  pwr_req, auto_off_en, start_in, alu_busy,
        output alu_pwr_en, iso_en, alu_rst_n, alu_ready, pwr_state
    );
endinterface

// File: rtl/alu_pwr_seq.sv
// Power sequencer for the gated ALU domain.
// Ramp up: supply -> reset release -> isolation release. Ramp down in reverse,
// after the ALU has drained. Optional idle auto-off, woken again by start_in.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// OFF      | domain unpowered, clamped, in reset
// RAMP_UP  | supply on, waiting RAMP_CYCLES for the rail to settle
// RST_REL  | reset released, outputs still clamped for ISO_SETUP cycles
// ON       | domain usable, idle timer running
// DRAIN    | no new work accepted, waiting for alu_busy to fall
// ISOLATE  | outputs clamped, reset still released for ISO_SETUP cycles
// RAMP_DN  | reset asserted, supply off, waiting RAMP_CYCLES
module alu_pwr_seq #(
    parameter int RAMP_CYCLES  = 4,
    parameter int ISO_SETUP    = 2,
    parameter int IDLE_TIMEOUT = 16,
    parameter int CNT_W        = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_pwr_seq_if.slave   bus
);

    localparam logic [CNT_W-1:0] RAMP_LD   = CNT_W'(RAMP_CYCLES - 1);
    localparam logic [CNT_W-1:0] ISO_LD    = CNT_W'(ISO_SETUP - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] IDLE_MAX  = CNT_W'(IDLE_TIMEOUT);

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_RAMP_UP = 3'd1,
        ST_RST_REL = 3'd2,
        ST_ON      = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_ISOLATE = 3'd5,
        ST_RAMP_DN = 3'd6
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] dwell_cnt;
    logic [CNT_W-1:0] idle_cnt;
    logic             auto_off_flag;
    logic             idle_cyc;
    logic             idle_timeout;
    logic             dwell_done;
    logic             pwr_en_q;
    logic             iso_q;
    logic             rst_n_q;
    logic             ready_q;

    // Output pattern {pwr_en, iso, rst_n, ready} for each state.
    function automatic logic [3:0] out_decode(input state_t s);
        case (s)
            ST_OFF:     out_decode = 4'b0100;
            ST_RAMP_UP: out_decode = 4'b1100;
            ST_RST_REL: out_decode = 4'b1110;
            ST_ON:      out_decode = 4'b1011;
            ST_DRAIN:   out_decode = 4'b1010;
            ST_ISOLATE: out_decode = 4'b1110;
            ST_RAMP_DN: out_decode = 4'b0100;
            default:    out_decode = 4'b0100;
        endcase
    endfunction

    // Dwell value loaded on entry so the state is held exactly N cycles.
    function automatic logic [CNT_W-1:0] dwell_load(input state_t s);
        case (s)
            ST_RAMP_UP, ST_RAMP_DN: dwell_load = RAMP_LD;
            ST_RST_REL, ST_ISOLATE: dwell_load = ISO_LD;
            default:                dwell_load = '0;
        endcase
    endfunction

    assign idle_cyc     = !bus.alu_busy && !bus.start_in;
    assign dwell_done   = (dwell_cnt == '0);
    // Saturated counts (auto-off enabled late) still count as timed out.
    assign idle_timeout = (state == ST_ON) && idle_cyc && bus.auto_off_en
                          && (idle_cnt >= IDLE_LAST);

    // Next-state selection; timed states never abort mid-sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_OFF:
                if (bus.pwr_req && (!auto_off_flag || bus.start_in))
                    state_nxt = ST_RAMP_UP;
            ST_RAMP_UP:
                if (dwell_done) state_nxt = ST_RST_REL;
            ST_RST_REL:
                if (dwell_done) state_nxt = ST_ON;
            ST_ON:
                if (!bus.pwr_req || idle_timeout) state_nxt = ST_DRAIN;
            ST_DRAIN:
                if (!bus.alu_busy) state_nxt = ST_ISOLATE;
            ST_ISOLATE:
                if (dwell_done) state_nxt = ST_RAMP_DN;
            ST_RAMP_DN:
                if (dwell_done) state_nxt = ST_OFF;
            default:
                state_nxt = ST_OFF;
        endcase
    end

    // State, counters, auto-off flag and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_OFF;
            dwell_cnt     <= '0;
            idle_cnt      <= '0;
            auto_off_flag <= 1'b0;
            pwr_en_q      <= 1'b0;
            iso_q         <= 1'b1;
            rst_n_q       <= 1'b0;
            ready_q       <= 1'b0;
        end else begin
            state <= state_nxt;
            {pwr_en_q, iso_q, rst_n_q, ready_q} <= out_decode(state_nxt);

            if (state_nxt != state)
                dwell_cnt <= dwell_load(state_nxt);
            else if (!dwell_done)
                dwell_cnt <= dwell_cnt - 1'b1;

            if (state != ST_ON || !idle_cyc)
                idle_cnt <= '0;
            else if (idle_cnt < IDLE_MAX)
                idle_cnt <= idle_cnt + 1'b1;

            if (!bus.pwr_req || bus.start_in)
                auto_off_flag <= 1'b0;
            else if (idle_timeout)
                auto_off_flag <= 1'b1;
        end
    end

    assign bus.alu_pwr_en = pwr_en_q;
    assign bus.iso_en     = iso_q;
    assign bus.alu_rst_n  = rst_n_q;
    assign bus.alu_ready  = ready_q;
    assign bus.pwr_state  = state;

endmodule

// File: tb/tb_alu_pwr_seq.sv
// Directed bench for alu_pwr_seq with default timing parameters.
module tb_alu_pwr_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_en  = 1'b0;

    alu_pwr_seq_if bus_if ();

    alu_pwr_seq #(
        .RAMP_CYCLES (4),
        .ISO_SETUP   (2),
        .IDLE_TIMEOUT(16),
        .CNT_W       (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Reference output table {pwr_en, iso, rst_n, ready} per state.
    function automatic logic [3:0] exp_outs(input logic [2:0] s);
        case (s)
            3'd0:    exp_outs = 4'b0100;
            3'd1:    exp_outs = 4'b1100;
            3'd2:    exp_outs = 4'b1110;
            3'd3:    exp_outs = 4'b1011;
            3'd4:    exp_outs = 4'b1010;
            3'd5:    exp_outs = 4'b1110;
            3'd6:    exp_outs = 4'b0100;
            default: exp_outs = 4'b1111;
        endcase
    endfunction

    // Ordering invariants and output decode, every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("inv_iso",
                (!(bus_if.alu_rst_n == 1'b0 || bus_if.alu_pwr_en == 1'b0)) || bus_if.iso_en, 1);
            chk("inv_ready", !bus_if.alu_ready || (bus_if.pwr_state == 3'd3), 1);
            chk("inv_rst_pwr", !bus_if.alu_rst_n || bus_if.alu_pwr_en, 1);
            chk("decode",
                {bus_if.alu_pwr_en, bus_if.iso_en, bus_if.alu_rst_n, bus_if.alu_ready},
                exp_outs(bus_if.pwr_state));
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input int n, input logic [2:0] s, input string tag);
        for (int i = 0; i < n; i++) begin
            step();
            chk(tag, bus_if.pwr_state, s);
        end
    endtask

    initial begin
        bus_if.pwr_req     = 1'b0;
        bus_if.auto_off_en = 1'b0;
        bus_if.start_in    = 1'b0;
        bus_if.alu_busy    = 1'b0;

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        chk("rst_state", bus_if.pwr_state, 0);
        chk("rst_outs", {bus_if.alu_pwr_en, bus_if.iso_en, bus_if.alu_rst_n, bus_if.alu_ready}, 4'b0100);
        @(negedge clk);
        @(negedge clk);
        rst_n          = 1'b1;
        mon_en         = 1'b1;
        bus_if.pwr_req = 1'b1;

        // Power-up walk: 1x4, 2x2, then ON
        step();
        chk("up_state0", bus_if.pwr_state, 1);
        chk("up_pwr_en", bus_if.alu_pwr_en, 1);
        chk("up_rst_held", bus_if.alu_rst_n, 0);
        hold(3, 1, "up_ramp");
        step();
        chk("up_rst_rel", bus_if.pwr_state, 2);
        chk("up_rst_n", bus_if.alu_rst_n, 1);
        chk("up_iso_held", bus_if.iso_en, 1);
        step();
        chk("up_rst_rel2", bus_if.pwr_state, 2);
        chk("up_not_ready", bus_if.alu_ready, 0);
        step();
        chk("up_on", bus_if.pwr_state, 3);
        chk("up_iso_rel", bus_if.iso_en, 0);
        chk("up_ready", bus_if.alu_ready, 1);
        hold(3, 3, "up_on_hold");

        // Drop request while busy for 10 cycles
        bus_if.alu_busy = 1'b1;
        bus_if.pwr_req  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("drain_hold", bus_if.pwr_state, 4);
            chk("drain_iso", bus_if.iso_en, 0);
        end
        bus_if.alu_busy = 1'b0;
        step();
        chk("dn_isolate", bus_if.pwr_state, 5);
        chk("dn_iso_on", bus_if.iso_en, 1);
        hold(1, 5, "dn_isolate2");
        hold(4, 6, "dn_ramp");
        hold(1, 0, "dn_off");

        // Idle auto-off after 16 idle cycles, then stay off until start
        bus_if.auto_off_en = 1'b1;
        bus_if.pwr_req     = 1'b1;
        hold(4, 1, "ao_ramp");
        hold(2, 2, "ao_rel");
        hold(16, 3, "ao_idle_on");
        hold(1, 4, "ao_drain");
        hold(2, 5, "ao_isolate");
        hold(4, 6, "ao_ramp_dn");
        hold(5, 0, "ao_stay_off");
        bus_if.start_in = 1'b1;
        step();
        bus_if.start_in = 1'b0;
        chk("ao_wake", bus_if.pwr_state, 1);
        hold(3, 1, "wake_ramp");
        hold(2, 2, "wake_rel");
        hold(1, 3, "wake_on");

        // Idle count reaches 15, start clears it, then a full 16 again
        hold(15, 3, "idle15");
        bus_if.start_in = 1'b1;
        step();
        bus_if.start_in = 1'b0;
        chk("idle_restart", bus_if.pwr_state, 3);
        hold(15, 3, "idle_again");
        step();
        chk("idle_timeout2", bus_if.pwr_state, 4);
        hold(2, 5, "it_isolate");
        hold(4, 6, "it_ramp_dn");
        hold(3, 0, "it_flag_off");

        // Request dropped during RAMP_UP: finish to ON, then drain
        bus_if.auto_off_en = 1'b0;
        bus_if.start_in    = 1'b1;
        step();
        bus_if.start_in = 1'b0;
        bus_if.pwr_req  = 1'b0;
        chk("na_ramp", bus_if.pwr_state, 1);
        hold(3, 1, "na_ramp2");
        hold(2, 2, "na_rel");
        step();
        chk("na_on", bus_if.pwr_state, 3);
        chk("na_ready", bus_if.alu_ready, 1);
        step();
        chk("na_drain", bus_if.pwr_state, 4);
        hold(2, 5, "na_isolate");
        hold(4, 6, "na_ramp_dn");
        hold(1, 0, "na_off");

        // Async reset during RST_REL
        bus_if.pwr_req = 1'b1;
        hold(4, 1, "ar_ramp");
        step();
        chk("ar_rst_rel", bus_if.pwr_state, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_outs", {bus_if.alu_pwr_en, bus_if.iso_en, bus_if.alu_rst_n, bus_if.alu_ready}, 4'b0100);
        chk("ar_state", bus_if.pwr_state, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("ar_restart", bus_if.pwr_state, 1);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_pwr_seq.md
# alu_pwr_seq

Power-sequencing controller for the gated ALU domain; sits directly upstream of the ALU wrapper and drives its `alu_pwr_en`, `iso_en` and domain reset. On request it ramps the domain up in a fixed order: supply, then reset release, then isolation release. It ramps the domain down in the reverse order once the ALU has drained. An optional idle timer powers the ALU off automatically, and a new `start` wakes it again.

## Interface

Parameters:
- `RAMP_CYCLES`, default 4: cycles allowed for supply ramp up and down; minimum 1.
- `ISO_SETUP`, default 2: cycles between reset release and isolation release, and between isolation assert and reset assert; minimum 1.
- `IDLE_TIMEOUT`, default 16: consecutive idle cycles in ON before auto-off; minimum 1.
- `CNT_W`, default 8: width of the internal counters; must hold max(RAMP_CYCLES, ISO_SETUP, IDLE_TIMEOUT).

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `pwr_req`  in  1  level; 1 = the ALU domain is wanted powered
- `auto_off_en`  in  1  level; enables the idle auto-off
- `start_in`  in  1  ALU start pulse; marks activity and wakes the domain from auto-off
- `alu_busy`  in  1  busy flag from the ALU
- `alu_pwr_en`  out  1  domain supply enable
- `iso_en`  out  1  output isolation enable (1 = clamp)
- `alu_rst_n`  out  1  domain reset, active-low
- `alu_ready`  out  1  domain is usable; `start` may be issued
- `pwr_state`  out  3  current FSM state encoding

## Operation

- Moore FSM; all outputs are registered and decoded from the state.
- States and their outputs (pwr_en / iso / rst_n / ready):
  - OFF=0: 0/1/0/0
  - RAMP_UP=1: 1/1/0/0
  - RST_REL=2: 1/1/1/0
  - ON=3: 1/0/1/1
  - DRAIN=4: 1/0/1/0
  - ISOLATE=5: 1/1/1/0
  - RAMP_DN=6: 0/1/0/0
- Reset (async): state OFF, all counters 0, `auto_off_flag` 0. Outputs are therefore `alu_pwr_en`=0, `iso_en`=1, `alu_rst_n`=0, `alu_ready`=0, `pwr_state`=0.
- Transitions:
  - OFF→RAMP_UP when `pwr_req`=1 and (`auto_off_flag`=0 or `start_in`=1). `start_in` clears `auto_off_flag`.
  - RAMP_UP→RST_REL after RAMP_CYCLES cycles.
  - RST_REL→ON after ISO_SETUP cycles.
  - ON→DRAIN when `pwr_req`=0, or when `auto_off_en`=1 and the idle count reaches IDLE_TIMEOUT. The auto-off case also sets `auto_off_flag`.
  - DRAIN→ISOLATE on the first cycle with `alu_busy`=0 (minimum 1 cycle in DRAIN).
  - ISOLATE→RAMP_DN after ISO_SETUP cycles.
  - RAMP_DN→OFF after RAMP_CYCLES cycles.
- Timed states: the dwell counter loads N−1 on entry and decrements. The state exits on the edge where the counter is 0, so the state is held exactly N cycles.
- Idle counter:
  - Active only in ON; cleared on entry to ON and in any cycle with `alu_busy`=1 or `start_in`=1.
  - Otherwise increments, saturating at IDLE_TIMEOUT.
  - Timeout occurs when the count equals IDLE_TIMEOUT−1 in an idle cycle, giving exactly IDLE_TIMEOUT idle cycles in ON.
- `auto_off_flag` is cleared whenever `pwr_req`=0 or `start_in`=1.
- No aborts: once RAMP_UP/RST_REL or ISOLATE/RAMP_DN is entered, the sequence runs to ON or OFF respectively. The request is then re-evaluated there.
- `pwr_req` dropping in ON with `alu_busy`=1: hold DRAIN until busy falls. Isolation is never asserted while busy.
- `start_in` while not in ON is not forwarded or queued; the upstream issuer must wait for `alu_ready`.

## Timing

- Power-up, `pwr_req` sampled 1 at edge 0 in OFF (defaults):
  - `alu_pwr_en`=1 after edge 0.
  - `alu_rst_n`=1 after edge 4.
  - `iso_en`=0 and `alu_ready`=1 after edge 6.
  - General: ON entered RAMP_CYCLES+ISO_SETUP cycles after the RAMP_UP entry edge.
- Power-down, `pwr_req`=0 sampled in ON at edge 0 with `alu_busy`=0:
  - DRAIN after edge 0, `alu_ready`=0.
  - ISOLATE after edge 1, `iso_en`=1.
  - RAMP_DN after edge 3, `alu_rst_n`=0 and `alu_pwr_en`=0.
  - OFF after edge 7.
- Ordering invariants, which the bench checks every cycle:
  - `iso_en`=1 whenever `alu_rst_n`=0 or `alu_pwr_en`=0.
  - `alu_ready`=1 only in ON.
  - `alu_rst_n`=1 implies `alu_pwr_en`=1.
- `rst_n` asserted mid-sequence: outputs go to reset values immediately (asynchronously); the FSM restarts from OFF.

## Test plan

- Reset then `pwr_req`=1 held → `pwr_state` walks 0,1×4,2×2,3; `alu_ready`=1 from cycle 7; ordering invariants hold throughout.
- In ON, `alu_busy`=1 for 10 cycles while `pwr_req`→0 → DRAIN held 10 cycles with `iso_en`=0; ISOLATE entered the cycle after busy falls; OFF reached 6 cycles later.
- `auto_off_en`=1, `pwr_req`=1, no activity → DRAIN after 16 idle cycles and OFF afterwards. The FSM stays in OFF while `pwr_req`=1; a `start_in` pulse → RAMP_UP on the next edge.
- Idle count 15, then a `start_in` pulse, then idle → no timeout until a further 16 idle cycles.
- `pwr_req` toggled 1→0 during RAMP_UP → sequence completes to ON, then enters DRAIN on the next edge.
- `rst_n` asserted low during RST_REL → outputs 0/1/0/0 within the same cycle; `pwr_state`=0.
